// File: rtl/tod_pkg.sv
// Shared widths, range limits and the hour-step result type used by the
// time-of-day counter and its helpers.
package tod_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [SEC_W-1:0]  SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX = 6'd59;
    localparam logic [HOUR_W-1:0] H24_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] H12_MIN = 5'd1;
    localparam logic [HOUR_W-1:0] H12_MAX = 5'd12;

    // Result of advancing the hour field by one in the active mode.
    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic              pm;
        logic              wrap;
    } hour_step_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises an asynchronous level into clk and emits a one-cycle pulse
// on each rising edge once the synchroniser holds a trustworthy history.
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_p;
    logic [SYNC_STAGES:0]   vld_p;
    logic                   primed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p <= '0;
            prev_p <= 1'b0;
            vld_p  <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], async_in};
            prev_p <= sync_p[SYNC_STAGES-1];
            vld_p  <= {vld_p[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // primed waits until the edge register reflects a value that entered the
    // chain after reset, so a level already high at release is not an edge.
    assign primed     = vld_p[SYNC_STAGES];
    assign edge_pulse = primed & sync_p[SYNC_STAGES-1] & ~prev_p;

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS counter advanced by the synchronised rising edge of a 1 Hz wave,
// with direct load, set-mode minute/hour increments and status pulses.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int HOURS_24    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    input  logic              run,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hours,
    input  logic [MIN_W-1:0]  load_mins,
    input  logic [SEC_W-1:0]  load_secs,
    input  logic              inc_min,
    input  logic              inc_hour,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  mins,
    output logic [SEC_W-1:0]  secs,
    output logic              pm,
    output logic              sec_pulse,
    output logic              day_wrap,
    output logic              load_err
);

    localparam bit                MODE_24  = (HOURS_24 != 0);
    localparam logic [HOUR_W-1:0] HOUR_RST = MODE_24 ? '0 : H12_MAX;

    logic edge_det;

    tick_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (tick_in),
        .edge_pulse(edge_det)
    );

    // In 12h mode the wrap flag marks 11 PM -> 12 AM, i.e. the start of a new day.
    function automatic hour_step_t step_hour(input logic [HOUR_W-1:0] h, input logic p);
        hour_step_t r;
        r.hours = h + 5'd1;
        r.pm    = p;
        r.wrap  = 1'b0;
        if (MODE_24) begin
            if (h == H24_MAX) begin
                r.hours = '0;
                r.wrap  = 1'b1;
            end
        end else begin
            if (h == H12_MAX) begin
                r.hours = H12_MIN;
            end else if (h == H12_MAX - 5'd1) begin
                r.hours = H12_MAX;
                r.pm    = ~p;
                r.wrap  = p;
            end
        end
        return r;
    endfunction

    function automatic logic load_valid(input logic [HOUR_W-1:0] h,
                                        input logic [MIN_W-1:0]  m,
                                        input logic [SEC_W-1:0]  s);
        logic hour_ok;
        if (MODE_24) hour_ok = (h <= H24_MAX);
        else         hour_ok = (h >= H12_MIN) && (h <= H12_MAX);
        return hour_ok && (m <= MIN_MAX) && (s <= SEC_MAX);
    endfunction

    logic [HOUR_W-1:0] hours_q, hours_n;
    logic [MIN_W-1:0]  mins_q, mins_n;
    logic [SEC_W-1:0]  secs_q, secs_n;
    logic              pm_q, pm_n;
    logic              pending_q, pending_n;
    logic              sec_pulse_q, sec_pulse_n;
    logic              day_wrap_q, day_wrap_n;
    logic              load_err_q, load_err_n;
    logic              edge_run;
    logic              sec_carry, min_carry;
    hour_step_t        hstep;

    assign edge_run  = edge_det & run;
    assign sec_carry = (secs_q == SEC_MAX);
    assign min_carry = (mins_q == MIN_MAX);
    assign hstep     = step_hour(hours_q, pm_q);

    always_comb begin
        hours_n     = hours_q;
        mins_n      = mins_q;
        secs_n      = secs_q;
        pm_n        = pm_q;
        pending_n   = pending_q;
        sec_pulse_n = 1'b0;
        day_wrap_n  = 1'b0;
        load_err_n  = 1'b0;

        if (load) begin
            pending_n = 1'b0;
            if (load_valid(load_hours, load_mins, load_secs)) begin
                hours_n = load_hours;
                mins_n  = load_mins;
                secs_n  = load_secs;
                pm_n    = 1'b0;
            end else begin
                load_err_n = 1'b1;
            end
        end else if (inc_min || inc_hour) begin
            if (inc_min) mins_n = min_carry ? '0 : mins_q + 6'd1;
            if (inc_hour) begin
                hours_n = hstep.hours;
                pm_n    = hstep.pm;
            end
            // A second arriving during a set strobe is held for the next free cycle.
            if (edge_run) pending_n = 1'b1;
        end else if (edge_run || pending_q) begin
            pending_n   = 1'b0;
            sec_pulse_n = 1'b1;
            secs_n      = sec_carry ? '0 : secs_q + 6'd1;
            if (sec_carry) begin
                mins_n = min_carry ? '0 : mins_q + 6'd1;
                if (min_carry) begin
                    hours_n    = hstep.hours;
                    pm_n       = hstep.pm;
                    day_wrap_n = hstep.wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours_q     <= HOUR_RST;
            mins_q      <= '0;
            secs_q      <= '0;
            pm_q        <= 1'b0;
            pending_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hours_q     <= hours_n;
            mins_q      <= mins_n;
            secs_q      <= secs_n;
            pm_q        <= pm_n;
            pending_q   <= pending_n;
            sec_pulse_q <= sec_pulse_n;
            day_wrap_q  <= day_wrap_n;
            load_err_q  <= load_err_n;
        end
    end

    assign hours     = hours_q;
    assign mins      = mins_q;
    assign secs      = secs_q;
    assign pm        = MODE_24 ? 1'b0 : pm_q;
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: one 24h and one 12h instance share
// the same stimulus; each scenario checks only the instance it targets.
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_mins = '0;
    logic [5:0] load_secs = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;

    logic [4:0] h24, h12;
    logic [5:0] m24, m12, s24, s12;
    logic       pm24, pm12, sp24, sp12, dw24, dw12, le24, le12;

    int n_total = 0;
    int n_bad   = 0;
    int sp_cnt24 = 0;
    int sp_cnt12 = 0;

    time_of_day_counter #(.HOURS_24(1), .SYNC_STAGES(2)) u24 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .load(load),
        .load_hours(load_hours), .load_mins(load_mins), .load_secs(load_secs),
        .inc_min(inc_min), .inc_hour(inc_hour),
        .hours(h24), .mins(m24), .secs(s24), .pm(pm24),
        .sec_pulse(sp24), .day_wrap(dw24), .load_err(le24)
    );

    time_of_day_counter #(.HOURS_24(0), .SYNC_STAGES(2)) u12 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .load(load),
        .load_hours(load_hours), .load_mins(load_mins), .load_secs(load_secs),
        .inc_min(inc_min), .inc_hour(inc_hour),
        .hours(h12), .mins(m12), .secs(s12), .pm(pm12),
        .sec_pulse(sp12), .day_wrap(dw12), .load_err(le12)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (sp24 === 1'b1) sp_cnt24++;
        if (sp12 === 1'b1) sp_cnt12++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int now24();
        return hms(int'(h24), int'(m24), int'(s24));
    endfunction

    function automatic int now12();
        return hms(int'(h12), int'(m12), int'(s12));
    endfunction

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(posedge clk); #1;
        load = 1'b1; load_hours = h; load_mins = m; load_secs = s;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic strobe(input bit hour);
        @(posedge clk); #1;
        if (hour) inc_hour = 1'b1; else inc_min = 1'b1;
        @(posedge clk); #1;
        inc_hour = 1'b0; inc_min = 1'b0;
    endtask

    // Raises tick_in and counts rising clk edges until the selected
    // instance shows sec_pulse; returns -1 if it never does.
    task automatic tick_rise(input bit sel12, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        @(posedge clk); #1;
        tick_in = 1'b1;
        while (!seen && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel12 ? sp12 : sp24) === 1'b1) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic tick_fall();
        tick_in = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int lat;
        int p24;
        int p12;

        // reset with tick_in already high
        reset = 1'b1; tick_in = 1'b1; run = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        p24 = sp_cnt24; p12 = sp_cnt12;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_time24", now24(), 0);
        check("rst_time12", now12(), hms(12, 0, 0));
        check("rst_pm12", int'(pm12), 0);
        check("rst_nopulse24", sp_cnt24 - p24, 0);
        check("rst_nopulse12", sp_cnt12 - p12, 0);
        check("rst_wrap24", int'(dw24), 0);
        check("rst_err24", int'(le24), 0);
        tick_fall();

        // 24h rollover and latency
        do_load(5'd23, 6'd59, 6'd58);
        @(negedge clk);
        check("ld_time24", now24(), hms(23, 59, 58));
        check("ld_err24", int'(le24), 0);
        tick_rise(1'b0, lat);
        check("lat1", lat, 3);
        check("t59_24", now24(), hms(23, 59, 59));
        check("t59_wrap", int'(dw24), 0);
        tick_fall();
        tick_rise(1'b0, lat);
        check("lat2", lat, 3);
        check("wrap_time24", now24(), 0);
        check("wrap_flag24", int'(dw24), 1);
        check("wrap_pulse24", int'(sp24), 1);
        @(negedge clk);
        check("wrap_flag_off", int'(dw24), 0);
        check("pulse_off", int'(sp24), 0);
        tick_fall();

        // 12h noon and midnight
        do_load(5'd11, 6'd59, 6'd59);
        @(negedge clk);
        check("ld_time12", now12(), hms(11, 59, 59));
        tick_rise(1'b1, lat);
        check("noon_time12", now12(), hms(12, 0, 0));
        check("noon_pm12", int'(pm12), 1);
        check("noon_wrap12", int'(dw12), 0);
        tick_fall();
        do_load(5'd11, 6'd59, 6'd59);
        @(negedge clk);
        check("reld_pm12", int'(pm12), 0);
        tick_rise(1'b1, lat);
        check("noon2_pm12", int'(pm12), 1);
        tick_fall();
        strobe(1'b1);
        @(negedge clk);
        check("inch_12to1", int'(h12), 1);
        check("inch_pm_keep", int'(pm12), 1);
        for (int i = 0; i < 10; i++) strobe(1'b1);
        for (int i = 0; i < 59; i++) strobe(1'b0);
        @(negedge clk);
        check("set_time12", now12(), hms(11, 59, 0));
        for (int i = 0; i < 59; i++) begin
            tick_rise(1'b1, lat);
            tick_fall();
        end
        @(negedge clk);
        check("pre_mid12", now12(), hms(11, 59, 59));
        check("pre_mid_pm", int'(pm12), 1);
        tick_rise(1'b1, lat);
        check("mid_time12", now12(), hms(12, 0, 0));
        check("mid_pm12", int'(pm12), 0);
        check("mid_wrap12", int'(dw12), 1);
        tick_fall();

        // load validation
        do_load(5'd5, 6'd6, 6'd7);
        do_load(5'd24, 6'd0, 6'd0);
        @(negedge clk);
        check("bad24_time", now24(), hms(5, 6, 7));
        check("bad24_err", int'(le24), 1);
        @(negedge clk);
        check("bad24_err_off", int'(le24), 0);
        do_load(5'd13, 6'd0, 6'd0);
        @(negedge clk);
        check("bad12_time", now12(), hms(5, 6, 7));
        check("bad12_err", int'(le12), 1);
        check("ok24_h13", now24(), hms(13, 0, 0));
        check("ok24_noerr", int'(le24), 0);
        do_load(5'd3, 6'd60, 6'd0);
        @(negedge clk);
        check("badmin_err", int'(le24), 1);
        check("badmin_time", now24(), hms(13, 0, 0));

        // increment coincident with a detected edge
        do_load(5'd10, 6'd20, 6'd30);
        @(posedge clk); #1;
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        inc_min = 1'b1;
        @(posedge clk); #1;
        inc_min = 1'b0;
        @(negedge clk);
        check("coin_inc", now24(), hms(10, 21, 30));
        check("coin_nopulse", int'(sp24), 0);
        @(negedge clk);
        check("coin_pend", now24(), hms(10, 21, 31));
        check("coin_pulse", int'(sp24), 1);
        tick_fall();

        // paused ticks are dropped
        run = 1'b0;
        p24 = sp_cnt24;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tick_in = 1'b1;
            repeat (5) @(posedge clk);
            #1 tick_in = 1'b0;
            repeat (5) @(posedge clk);
        end
        @(negedge clk);
        check("pause_time", now24(), hms(10, 21, 31));
        check("pause_nopulse", sp_cnt24 - p24, 0);
        run = 1'b1;
        p24 = sp_cnt24;
        tick_rise(1'b0, lat);
        check("resume_lat", lat, 3);
        check("resume_time", now24(), hms(10, 21, 32));
        tick_fall();
        check("resume_one", sp_cnt24 - p24, 1);

        // asynchronous reset mid-operation
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst24", now24(), 0);
        check("midrst12", now12(), hms(12, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
